regfile_init: RTL

REGFILE_INIT -- requirements
Module: regfile_init

---
 rtl/regfile_init.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_init.sv
// Multi-port register file that loads its contents from the INIT parameter one
// entry per cycle after reset or on request, then serves two combinational reads.
module regfile_init #(
   parameter int                     WIDTH  = 8,
   parameter int                     DEPTH  = 16,
   parameter logic [DEPTH*WIDTH-1:0] INIT   = '0,
   parameter bit                     BYPASS = 1'b1,
   localparam int                    AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_req,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   output logic             ready,
   output logic             dbg_state
);

   localparam logic [0:0]    ST_INIT  = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] init_val;
   logic             user_wr;
   logic             fwd_en;

   always_comb begin
      init_val = INIT[int'(ptr_q)*WIDTH +: WIDTH];
   end

   // A simultaneous init_req cancels the user write and its forwarding.
   always_comb begin
      user_wr = (state_q == ST_RUN) && we && !init_req;
      fwd_en  = (BYPASS != 1'b0) && user_wr;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ready_d = ready_q;
      case (state_q)
         ST_INIT: begin
            if (ptr_q == PTR_LAST) begin
               state_d = ST_RUN;
               ptr_d   = '0;
               ready_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            if (init_req) begin
               state_d = ST_INIT;
               ptr_d   = '0;
               ready_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
      end
   end

   // Storage has no reset of its own; the sweep that follows reset restores it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= init_val;
         end else if (user_wr) begin
            mem_q[waddr] <= wdata;
         end
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (rst_n && (state_q == ST_RUN)) begin
         rdata_a = (fwd_en && (raddr_a == waddr)) ? wdata : mem_q[raddr_a];
         rdata_b = (fwd_en && (raddr_b == waddr)) ? wdata : mem_q[raddr_b];
      end
   end

   assign ready     = ready_q;
   assign dbg_state = state_q;

endmodule
